// File: rtl/sound_pkg.sv
// sound_pkg: shared definitions for the oscillator blocks.
//   wave_e  : waveform select encoding (SINE, SQUARE, TRI, SAW)
//   sine_q  : elaboration-time quarter-wave table entry,
//             round(MAX * sin(pi/2 * k / 2^lut_aw)), MAX = 2^out_w - 1
package sound_pkg;

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    SQUARE = 2'd1,
    TRI    = 2'd2,
    SAW    = 2'd3
  } wave_e;

  // Taylor series on [0, pi/2]; 12 terms is far below double rounding there.
  function automatic int sine_q(input int k, input int lut_aw, input int out_w);
    real x, term, s, mx;
    x    = (3.14159265358979323846 / 2.0) * (real'(k) / real'(1 << lut_aw));
    term = x;
    s    = x;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
      s    = s + term;
    end
    mx = real'((1 << out_w) - 1);
    return $rtoi(mx * s + 0.5);
  endfunction

endpackage

// File: rtl/sine_qlut.sv
// sine_qlut: combinational quarter-wave sine table.
//   i_idx : table index 0 .. 2^LUT_AW (the extra top entry holds MAX so the
//           mirrored quadrants can address the peak directly)
//   o_mag : unsigned magnitude, OUT_W bits
module sine_qlut #(
  parameter int OUT_W  = 9,
  parameter int LUT_AW = 6
) (
  input  logic [LUT_AW:0]  i_idx,
  output logic [OUT_W-1:0] o_mag
);
  import sound_pkg::*;

  localparam int N = (1 << LUT_AW) + 1;

  logic [OUT_W-1:0] w_tab [0:N-1];

  for (genvar k = 0; k < N; k++) begin : g_tab
    localparam int V = sine_q(k, LUT_AW, OUT_W);
    assign w_tab[k] = OUT_W'(V);
  end

  assign o_mag = w_tab[i_idx];

endmodule

// File: rtl/dds_osc.sv
// dds_osc: direct digital synthesis oscillator, sign-split output.
//   clk, reset      : clock, synchronous active-high reset
//   sample_en       : one-cycle sample strobe
//   enable          : run; low clears phase and silences the output
//   wave_sel        : 0 sine, 1 square, 2 triangle, 3 sawtooth
//   tuning          : phase increment per sample
//   amplitude       : unsigned output scale (all ones = unity)
//   pos_out/neg_out : magnitude on the side of the sample's sign, other side 0
//   out_valid       : new sample present (2 edges after the strobe)
//   cycle_start     : this sample's increment carried out of the accumulator
module dds_osc #(
  parameter int OUT_W   = 9,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6,
  parameter int AMP_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic               enable,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] tuning,
  input  logic [AMP_W-1:0]   amplitude,
  output logic [OUT_W-1:0]   pos_out,
  output logic [OUT_W-1:0]   neg_out,
  output logic               out_valid,
  output logic               cycle_start
);
  import sound_pkg::*;

  localparam logic [OUT_W-1:0]  MAX = '1;
  localparam logic [LUT_AW:0]   QTR = (LUT_AW + 1)'(1) << LUT_AW;

  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_tuning;
  wave_e              r_wave;
  logic [AMP_W-1:0]   r_amp;

  // stage 1: decoded magnitude/sign plus the amplitude it will be scaled by
  logic               r_s1_vld;
  logic [OUT_W-1:0]   r_s1_mag;
  logic               r_s1_neg;
  logic               r_s1_wrap;
  logic [AMP_W-1:0]   r_s1_amp;

  logic [PHASE_W:0]   w_sum;
  logic               w_carry;
  logic               w_msb;
  logic               w_q0;
  logic [LUT_AW-1:0]  w_i;
  logic [LUT_AW:0]    w_lut_idx;
  logic [OUT_W-1:0]   w_sine;
  logic [OUT_W-1:0]   w_mag;
  logic               w_neg;
  logic               w_load;
  logic [OUT_W+AMP_W-1:0] w_prod;
  logic [OUT_W-1:0]   w_scaled;

  assign w_sum   = {1'b0, r_phase} + {1'b0, r_tuning};
  assign w_carry = w_sum[PHASE_W];
  assign w_msb   = r_phase[PHASE_W-1];
  assign w_q0    = r_phase[PHASE_W-2];
  assign w_i     = r_phase[PHASE_W-3 -: LUT_AW];

  // odd quadrants run the table backwards; i = 0 lands on the MAX entry
  assign w_lut_idx = w_q0 ? (QTR - {1'b0, w_i}) : {1'b0, w_i};

  sine_qlut #(.OUT_W(OUT_W), .LUT_AW(LUT_AW)) u_qlut (
    .i_idx (w_lut_idx),
    .o_mag (w_sine)
  );

  // Top bits of an inverted field equal the inverted top bits, so the
  // triangle/saw folds are done on the OUT_W-bit slice only.
  always_comb begin
    w_mag = '0;
    w_neg = w_msb;
    case (r_wave)
      SINE:   w_mag = w_sine;
      SQUARE: w_mag = MAX;
      TRI:    w_mag = r_phase[PHASE_W-3 -: OUT_W] ^ {OUT_W{w_q0}};
      SAW: begin
        w_mag = r_phase[PHASE_W-2 -: OUT_W] ^ {OUT_W{~w_msb}};
        w_neg = ~w_msb;
      end
      default: ;
    endcase
  end

  // Parameters follow the inputs while idle; while running they only change
  // at a period boundary (or when stalled at zero tuning) to avoid glitches.
  assign w_load = ~enable | (sample_en & (w_carry | (r_tuning == '0)));

  assign w_prod   = {{AMP_W{1'b0}}, r_s1_mag} * {{OUT_W{1'b0}}, r_s1_amp};
  assign w_scaled = (&r_s1_amp) ? r_s1_mag : OUT_W'(w_prod >> AMP_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase     <= '0;
      r_tuning    <= '0;
      r_wave      <= SINE;
      r_amp       <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_mag    <= '0;
      r_s1_neg    <= 1'b0;
      r_s1_wrap   <= 1'b0;
      r_s1_amp    <= '0;
      pos_out     <= '0;
      neg_out     <= '0;
      out_valid   <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      if (w_load) begin
        r_tuning <= tuning;
        r_wave   <= wave_e'(wave_sel);
        r_amp    <= amplitude;
      end

      if (!enable) begin
        r_phase   <= '0;
        r_s1_vld  <= 1'b0;
        r_s1_mag  <= '0;
        r_s1_neg  <= 1'b0;
        r_s1_wrap <= 1'b0;
        r_s1_amp  <= '0;
      end else if (sample_en) begin
        r_phase   <= w_sum[PHASE_W-1:0];
        r_s1_vld  <= 1'b1;
        r_s1_mag  <= w_mag;
        r_s1_neg  <= w_neg;
        r_s1_wrap <= w_carry;
        r_s1_amp  <= r_amp;
      end else begin
        r_s1_vld  <= 1'b0;
      end

      // stage 2 reloads every cycle; stage 1 holds its data between strobes
      out_valid   <= r_s1_vld;
      cycle_start <= r_s1_vld & r_s1_wrap;
      pos_out     <= r_s1_neg ? '0 : w_scaled;
      neg_out     <= r_s1_neg ? w_scaled : '0;
    end
  end

endmodule

// File: tb/tb_dds_osc.sv
module tb_dds_osc;

  logic        clk = 1'b0;
  logic        rst;
  logic        sen;
  logic        en;
  logic [1:0]  wsel;
  logic [15:0] tun;
  logic [7:0]  amp;
  logic [8:0]  pos_out, neg_out;
  logic        out_valid, cycle_start;

  always #5 clk = ~clk;

  dds_osc #(.OUT_W(9), .PHASE_W(16), .LUT_AW(6), .AMP_W(8)) dut (
    .clk         (clk),
    .reset       (rst),
    .sample_en   (sen),
    .enable      (en),
    .wave_sel    (wsel),
    .tuning      (tun),
    .amplitude   (amp),
    .pos_out     (pos_out),
    .neg_out     (neg_out),
    .out_valid   (out_valid),
    .cycle_start (cycle_start)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model state
  int m_phase = 0, m_tun = 0, m_wave = 0, m_amp = 0;
  bit p_vld = 0, p_cs = 0;
  int p_pos = 0, p_neg = 0;
  bit silent = 1, prev_kill = 1;

  int lg_pos[$], lg_neg[$], lg_cs[$];

  // waveform value of one sample, straight from the waveform definitions
  task automatic msamp(input int p, input int w, input int a, output int pos, output int neg);
    int msb, q, i, k, mag, v, s;
    bit ng;
    msb = (p >> 15) & 1;
    q   = (p >> 14) & 3;
    i   = (p >> 8) & 63;
    ng  = (msb == 1);
    mag = 0;
    case (w)
      0: begin
        k   = (q & 1) ? 64 - i : i;
        mag = $rtoi(511.0 * $sin(3.14159265358979323846 * real'(k) / 128.0) + 0.5);
      end
      1: mag = 511;
      2: begin
        v   = p & 16383;
        if (q & 1) v = 16383 - v;
        mag = v >> 5;
      end
      default: begin
        v   = p & 32767;
        mag = msb ? (v >> 6) : ((32767 - v) >> 6);
        ng  = (msb == 0);
      end
    endcase
    s   = (a == 255) ? mag : (mag * a) >> 8;
    pos = ng ? 0 : s;
    neg = ng ? s : 0;
  endtask

  task automatic step();
    bit e_vld, e_cs, n_vld, n_cs, load;
    int e_pos, e_neg, n_pos, n_neg, sum;
    @(posedge clk);
    e_vld  = !rst && p_vld;
    e_cs   = !rst && p_cs;
    e_pos  = p_pos;
    e_neg  = p_neg;
    silent = rst || prev_kill || (silent && !p_vld);
    prev_kill = rst || !en;
    n_vld = 0; n_cs = 0; n_pos = 0; n_neg = 0;
    if (rst) begin
      m_phase = 0; m_tun = 0; m_wave = 0; m_amp = 0;
    end else if (!en) begin
      m_phase = 0; m_tun = int'(tun); m_wave = int'(wsel); m_amp = int'(amp);
    end else if (sen) begin
      msamp(m_phase, m_wave, m_amp, n_pos, n_neg);
      n_vld = 1;
      sum   = m_phase + m_tun;
      n_cs  = (sum >= 65536);
      load  = n_cs || (m_tun == 0);
      m_phase = sum % 65536;
      if (load) begin
        m_tun = int'(tun); m_wave = int'(wsel); m_amp = int'(amp);
      end
    end
    p_vld = n_vld; p_cs = n_cs; p_pos = n_pos; p_neg = n_neg;
    #1;
    chk("out_valid", out_valid, e_vld);
    chk("cycle_start", cycle_start, e_cs);
    if (e_vld) begin
      chk("pos_out", pos_out, e_pos);
      chk("neg_out", neg_out, e_neg);
    end else if (silent) begin
      chk("silent_pos", pos_out, 0);
      chk("silent_neg", neg_out, 0);
    end
    chk("both_sides", (pos_out != 0) && (neg_out != 0), 0);
    if (out_valid) begin
      lg_pos.push_back(int'(pos_out));
      lg_neg.push_back(int'(neg_out));
      lg_cs.push_back(int'(cycle_start));
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clr_log();
    lg_pos.delete(); lg_neg.delete(); lg_cs.delete();
  endtask

  // idle one cycle so the new settings load, then run continuous strobes
  task automatic start(input int w, input int t, input int a);
    en = 0; sen = 0; wsel = 2'(w); tun = 16'(t); amp = 8'(a);
    step();
    clr_log();
    en = 1; sen = 1;
  endtask

  initial begin
    rst = 1; sen = 1; en = 1; wsel = 2'd1; tun = 16'h1234; amp = 8'd200;
    steps(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_pos", pos_out, 0);
    chk("rst_neg", neg_out, 0);
    chk("rst_cs", cycle_start, 0);
    rst = 0;

    // sine, 64 samples per period
    start(0, 1024, 255);
    steps(70);
    if (lg_pos.size() >= 66) begin
      chk("sin_s0_pos", lg_pos[0], 0);
      chk("sin_s0_neg", lg_neg[0], 0);
      chk("sin_s16_pos", lg_pos[16], 511);
      chk("sin_s48_neg", lg_neg[48], 511);
      chk("sin_s62_cs", lg_cs[62], 0);
      chk("sin_s63_cs", lg_cs[63], 1);
    end else chk("sin_count", lg_pos.size(), 66);

    // mid-stream reset drops in-flight samples
    steps(5);
    rst = 1;
    steps(2);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pos", pos_out, 0);
    chk("mid_rst_neg", neg_out, 0);
    rst = 0;
    step();
    chk("post_rst_valid", out_valid, 0);

    // square at half amplitude
    start(1, 1024, 128);
    steps(66);
    if (lg_pos.size() >= 64) begin
      chk("sq_s0_pos", lg_pos[0], 255);
      chk("sq_s31_pos", lg_pos[31], 255);
      chk("sq_s32_neg", lg_neg[32], 255);
      chk("sq_s63_neg", lg_neg[63], 255);
      chk("sq_s32_pos", lg_pos[32], 0);
    end else chk("sq_count", lg_pos.size(), 64);

    // triangle, quarter-period steps
    start(2, 16'h4000, 255);
    steps(10);
    if (lg_pos.size() >= 6) begin
      chk("tri_s0", lg_pos[0] + lg_neg[0], 0);
      chk("tri_s1_pos", lg_pos[1], 511);
      chk("tri_s2", lg_pos[2] + lg_neg[2], 0);
      chk("tri_s3_neg", lg_neg[3], 511);
      chk("tri_s5_pos", lg_pos[5], 511);
    end else chk("tri_count", lg_pos.size(), 6);

    // tuning change mid-period waits for the wrap
    start(3, 1024, 255);
    steps(10);
    tun = 16'd2048;
    steps(100);
    if (lg_cs.size() >= 100) begin
      chk("retune_cs63", lg_cs[63], 1);
      chk("retune_cs94", lg_cs[94], 0);
      chk("retune_cs95", lg_cs[95], 1);
    end else chk("retune_count", lg_cs.size(), 100);

    // enable drop mid-period, then restart from phase 0 (saw: full negative)
    en = 0;
    steps(2);
    chk("dis_pos", pos_out, 0);
    chk("dis_neg", neg_out, 0);
    chk("dis_valid", out_valid, 0);
    step();
    clr_log();
    en = 1;
    steps(4);
    if (lg_neg.size() >= 1) chk("reen_s0_neg", lg_neg[0], 511);
    else chk("reen_count", lg_neg.size(), 1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 39) != 0);
      sen  = ($urandom_range(0, 1) == 1);
      wsel = 2'($urandom_range(0, 3));
      amp  = ($urandom_range(0, 2) == 0) ? 8'd255 : 8'($urandom);
      case ($urandom_range(0, 3))
        0:       tun = 16'd0;
        1:       tun = 16'($urandom_range(1, 64)) << 8;
        default: tun = 16'($urandom);
      endcase
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
